opo_lock_servo: RTL
===================

OPO_LOCK_SERVO -- requirements
Module: opo_lock_servo

Interface
REQ-001 SHALL have parameter word_width, default 14: DAC output width; the error input is 2*word_width.
REQ-002 SHALL have parameter decim_log2, default 8: error sample period is 2^decim_log2 clk cycles.
REQ-003 SHALL have port clk, in, 1: 250 MHz system clock; the only clock.
REQ-004 SHALL have port rst, in, 1: synchronous, active-high reset.
REQ-005 SHALL have port enable, in, 1: servo run request.
REQ-006 SHALL have port polarity, in, 1: 1 negates error_in before use.
REQ-007 SHALL have port error_in, in, 2*word_width signed: lock-in Q output used as error signal.
REQ-008 SHALL have ports kp_shift and ki_shift, in, 5 each: proportional and integral gains as arithmetic right shifts.
REQ-009 SHALL have ports sweep_min and sweep_max, in, word_width signed: actuator limits.
REQ-010 SHALL have port sweep_step, in, word_width unsigned: sweep increment per sample.
REQ-011 SHALL have port lock_threshold, in, 2*word_width unsigned: capture and hold window on |error|.
REQ-012 SHALL have port unlock_count, in, 8: consecutive out-of-window samples that declare loss of lock.
REQ-013 SHALL have port dac_out, out, word_width signed: actuator (piezo) drive.
REQ-014 SHALL have port state_out, out, 2: IDLE=0, SWEEP=1, LOCK=2.
REQ-015 SHALL have port locked, out, 1: high exactly when state is LOCK.

Function
REQ-016 SHALL run a free decimation counter from 0 to 2^decim_log2-1; strobe is asserted for one cycle when it wraps to 0.
REQ-017 SHALL register e = polarity ? -error_in : error_in on each strobe; -min(error_in) SHALL saturate to max positive.
REQ-018 SHALL make all state, sweep and integrator updates only on strobe cycles, except transitions to IDLE.
REQ-019 SHALL update dac_out one cycle after the strobe that produced it and hold it between strobes.
REQ-020 IDLE: dac_out=0 and integrator=0; on the first strobe with enable=1, go to SWEEP with position=sweep_min and direction up.
REQ-021 SWEEP: position += sweep_step (up) or -= sweep_step (down); at or past sweep_max, clamp to sweep_max and set direction down; at or below sweep_min, clamp to sweep_min and set direction up; dac_out=position.
REQ-022 SWEEP with sweep_min >= sweep_max: position holds at sweep_min.
REQ-023 SWEEP to LOCK on a strobe where |e| < lock_threshold: integrator preloaded with the current position, miss counter cleared, dac_out unchanged that strobe.
REQ-024 LOCK: integ_next = sat(integrator + (e >>> ki_shift)); dac_out = sat(integ_next + (e >>> kp_shift)); sat clamps to [sweep_min, sweep_max]; internal sums SHALL be wide enough that they never overflow before saturation.
REQ-025 LOCK: miss counter increments on each strobe with |e| >= lock_threshold and clears when |e| < lock_threshold.
REQ-026 LOCK to SWEEP when the miss counter reaches unlock_count (unlock_count=0 treated as 1), or when integ_next saturates at either limit; sweep resumes from the saturated value, direction away from that limit.
REQ-027 enable=0 in any state SHALL force IDLE on the next clk edge regardless of strobe, zeroing dac_out and integrator.
REQ-028 SHALL treat simultaneous lock-loss conditions in one strobe as a single transition to SWEEP.

Reset
REQ-029 With rst=1 on a clk edge: state=IDLE, dac_out=0, locked=0, state_out=0, integrator=0, miss counter=0, decimation counter=0, direction up; mid-operation reset SHALL take effect on that edge.

Verification
REQ-030 decim_log2=2, enable=1, min=-100, max=100, step=40, error_in=1e6, threshold=10 -> dac_out sequence -100,-60,-20,20,60,100,60 at every 4th cycle; state_out=1.
REQ-031 Same sweep, error_in=5 while position is 20 -> state_out=2 and locked=1 after that strobe, dac_out holds 20.
REQ-032 In LOCK at 20, kp_shift=2, ki_shift=4, error_in=64 for 3 strobes, threshold=100 -> integrator 24,28,32 and dac_out 40,44,48.
REQ-033 In LOCK, unlock_count=3, error_in=500 (threshold 100) -> SWEEP exactly on the 3rd strobe; 2 misses then error_in=0 -> stays LOCK.
REQ-034 In LOCK, drive error to push the integrator past 100 -> dac_out=100, next state SWEEP with direction down; polarity=1 with error_in=-64 reproduces the REQ-032 values.
REQ-035 Deassert enable mid-LOCK, and separately assert rst mid-SWEEP -> next edge dac_out=0 and state_out=0.

Source files
------------

// File: rtl/opo_lock_servo.sv
`default_nettype none
// ============================================================================
// Module  : opo_lock_servo
// Brief   : Sweep-and-lock PI servo driving an OPO cavity piezo from a
//           decimated lock-in error signal.
// Rev     : 1.0  initial release
// ============================================================================
module opo_lock_servo #(
    parameter int word_width = 14,
    parameter int decim_log2 = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           polarity,
    input  logic signed [2*word_width-1:0] error_in,
    input  logic [4:0]                     kp_shift,
    input  logic [4:0]                     ki_shift,
    input  logic signed [word_width-1:0]   sweep_min,
    input  logic signed [word_width-1:0]   sweep_max,
    input  logic [word_width-1:0]          sweep_step,
    input  logic [2*word_width-1:0]        lock_threshold,
    input  logic [7:0]                     unlock_count,
    output logic signed [word_width-1:0]   dac_out,
    output logic [1:0]                     state_out,
    output logic                           locked
);
    localparam int c_ew = 2 * word_width;
    localparam int c_sw = c_ew + 2;
    localparam int c_xw = c_sw - word_width;
    localparam logic signed [c_ew-1:0]       c_emin    = {1'b1, {(c_ew-1){1'b0}}};
    localparam logic signed [c_ew-1:0]       c_emax    = {1'b0, {(c_ew-1){1'b1}}};
    localparam logic [decim_log2-1:0]        c_cnt_one = decim_log2'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;

    state_t                       r_state, w_state_nxt;
    logic [decim_log2-1:0]        r_cnt;
    logic                         r_strobe;
    logic                         r_upd;
    logic signed [c_ew-1:0]       r_e, w_e;
    logic signed [word_width-1:0] r_pos, w_pos_nxt;
    logic signed [word_width-1:0] r_integ, w_integ_nxt;
    logic signed [word_width-1:0] r_dac, w_dac_nxt;
    logic                         r_dir, w_dir_nxt;
    logic [7:0]                   r_miss, w_miss_nxt;

    // Error capture: negation saturates so the most negative code cannot wrap.
    always_comb begin
        w_e = error_in;
        if (polarity) begin
            w_e = (error_in == c_emin) ? c_emax : -error_in;
        end
    end

    logic signed [c_ew:0] w_e_x;
    logic [c_ew:0]        w_abs;
    logic                 w_in_win;
    assign w_e_x    = {r_e[c_ew-1], r_e};
    assign w_abs    = w_e_x[c_ew] ? unsigned'(-w_e_x) : unsigned'(w_e_x);
    assign w_in_win = (w_abs < {1'b0, lock_threshold});

    // PI datapath, evaluated two bits wider than the error so nothing wraps.
    logic signed [c_ew-1:0]       w_pterm, w_iterm;
    logic signed [c_sw-1:0]       w_min_x, w_max_x, w_pos_x, w_step_x, w_integ_x;
    logic signed [c_sw-1:0]       w_pterm_x, w_iterm_x, w_integ_raw, w_isat_x, w_out_raw;
    logic signed [c_sw-1:0]       w_up, w_dn;
    logic signed [word_width-1:0] w_integ_sat, w_out_sat;
    logic                         w_integ_hi, w_integ_lo;

    assign w_pterm     = r_e >>> kp_shift;
    assign w_iterm     = r_e >>> ki_shift;
    assign w_pterm_x   = {{2{w_pterm[c_ew-1]}}, w_pterm};
    assign w_iterm_x   = {{2{w_iterm[c_ew-1]}}, w_iterm};
    assign w_min_x     = {{c_xw{sweep_min[word_width-1]}}, sweep_min};
    assign w_max_x     = {{c_xw{sweep_max[word_width-1]}}, sweep_max};
    assign w_pos_x     = {{c_xw{r_pos[word_width-1]}}, r_pos};
    assign w_step_x    = {{c_xw{1'b0}}, sweep_step};
    assign w_integ_x   = {{c_xw{r_integ[word_width-1]}}, r_integ};
    assign w_up        = w_pos_x + w_step_x;
    assign w_dn        = w_pos_x - w_step_x;

    assign w_integ_raw = w_integ_x + w_iterm_x;
    assign w_integ_hi  = (w_integ_raw >= w_max_x);
    assign w_integ_lo  = (w_integ_raw <= w_min_x);
    assign w_integ_sat = w_integ_hi ? sweep_max :
                         w_integ_lo ? sweep_min : w_integ_raw[word_width-1:0];
    assign w_isat_x    = {{c_xw{w_integ_sat[word_width-1]}}, w_integ_sat};
    assign w_out_raw   = w_isat_x + w_pterm_x;
    assign w_out_sat   = (w_out_raw >= w_max_x) ? sweep_max :
                         (w_out_raw <= w_min_x) ? sweep_min : w_out_raw[word_width-1:0];

    logic [8:0] w_miss_inc, w_unlock_lim;
    logic       w_miss_out;
    assign w_miss_inc   = {1'b0, r_miss} + 9'd1;
    assign w_unlock_lim = (unlock_count == 8'd0) ? 9'd1 : {1'b0, unlock_count};
    assign w_miss_out   = !w_in_win && (w_miss_inc >= w_unlock_lim);

    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_dir_nxt   = r_dir;
        w_integ_nxt = r_integ;
        w_miss_nxt  = r_miss;
        w_dac_nxt   = r_dac;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_dir_nxt   = 1'b0;
            w_integ_nxt = '0;
            w_miss_nxt  = '0;
            w_dac_nxt   = '0;
        end else if (r_upd) begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_SWEEP;
                    w_pos_nxt   = sweep_min;
                    w_dir_nxt   = 1'b0;
                    w_dac_nxt   = sweep_min;
                end
                ST_SWEEP: begin
                    if (w_in_win) begin
                        w_state_nxt = ST_LOCK;
                        w_integ_nxt = r_pos;
                        w_miss_nxt  = '0;
                    end else begin
                        if (sweep_min >= sweep_max) begin
                            w_pos_nxt = sweep_min;
                        end else if (!r_dir) begin
                            if (w_up >= w_max_x) begin
                                w_pos_nxt = sweep_max;
                                w_dir_nxt = 1'b1;
                            end else begin
                                w_pos_nxt = w_up[word_width-1:0];
                            end
                        end else begin
                            if (w_dn <= w_min_x) begin
                                w_pos_nxt = sweep_min;
                                w_dir_nxt = 1'b0;
                            end else begin
                                w_pos_nxt = w_dn[word_width-1:0];
                            end
                        end
                        w_dac_nxt = w_pos_nxt;
                    end
                end
                ST_LOCK: begin
                    w_integ_nxt = w_integ_sat;
                    w_dac_nxt   = w_out_sat;
                    w_miss_nxt  = w_in_win ? 8'd0 : w_miss_inc[7:0];
                    // Any loss condition resumes the sweep from the integrator value.
                    if (w_integ_hi || w_integ_lo || w_miss_out) begin
                        w_state_nxt = ST_SWEEP;
                        w_pos_nxt   = w_integ_sat;
                        w_dir_nxt   = w_integ_hi;
                        w_dac_nxt   = w_integ_sat;
                        w_miss_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_dac_nxt   = '0;
                    w_integ_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_strobe <= 1'b0;
            r_upd    <= 1'b0;
            r_e      <= '0;
            r_state  <= ST_IDLE;
            r_pos    <= '0;
            r_dir    <= 1'b0;
            r_integ  <= '0;
            r_miss   <= '0;
            r_dac    <= '0;
        end else begin
            r_cnt    <= r_cnt + c_cnt_one;
            r_strobe <= (r_cnt == '1);
            r_upd    <= r_strobe;
            if (r_strobe) begin
                r_e <= w_e;
            end
            r_state  <= w_state_nxt;
            r_pos    <= w_pos_nxt;
            r_dir    <= w_dir_nxt;
            r_integ  <= w_integ_nxt;
            r_miss   <= w_miss_nxt;
            r_dac    <= w_dac_nxt;
        end
    end

    assign dac_out   = r_dac;
    assign state_out = r_state;
    assign locked    = (r_state == ST_LOCK);

endmodule
`default_nettype wire
